// File: rtl/audio_avg_filter.sv
// ---------------------------------------------------------------------------
// audio_avg_filter
//
// Moving-average noise filter for one audio channel. It keeps the last
// 2^LOG2_DEPTH signed samples in a circular buffer together with a running
// sum. For every accepted input it emits the floor average of the window.
// Samples that have not arrived yet count as zero, so during the initial
// fill the output is sum / N and not sum / cnt.
//
// Parameters:
//   DATA_W     sample width, two's complement
//   LOG2_DEPTH log2 of the window length N (legal range 1..8)
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   upstream sample present
//   in_data    signed input sample
//   in_ready   block accepts a sample this cycle (combinational)
//   out_valid  filtered sample present
//   out_data   signed filtered sample
//   out_ready  downstream accepts the sample
//   bypass     (only with AUDIO_AVG_BYPASS_EN) pass in_data straight to
//              out_data; the window still updates
//
// Optional feature macro: AUDIO_AVG_BYPASS_EN
// ---------------------------------------------------------------------------
module audio_avg_filter #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef AUDIO_AVG_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned AccW  = DATA_W + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0]   CntFull = Depth[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0]   CntOne  = 1;
  localparam logic [LOG2_DEPTH-1:0] WpOne   = 1;

  // Sample window; contents are masked by cnt_q after reset, so no reset.
  logic [DATA_W-1:0]     sample_mem_q [Depth];

  logic [AccW-1:0]       acc_q, acc_d;
  logic [LOG2_DEPTH-1:0] wp_q, wp_d;
  logic [LOG2_DEPTH:0]   cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  logic                  accept;
  logic                  full;
  logic [DATA_W-1:0]     old_sample;
  logic [AccW-1:0]       new_ext;
  logic [AccW-1:0]       old_ext;
  logic [DATA_W-1:0]     avg;
  logic                  use_bypass;

`ifdef AUDIO_AVG_BYPASS_EN
  assign use_bypass = bypass;
`else
  assign use_bypass = 1'b0;
`endif

  // A stalled output blocks new input so the held result is never lost.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    full       = (cnt_q == CntFull);
    // Before the window is full the slot being overwritten holds nothing
    // that is part of the sum.
    old_sample = full ? sample_mem_q[wp_q] : '0;
    new_ext    = {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data};
    old_ext    = {{LOG2_DEPTH{old_sample[DATA_W-1]}}, old_sample};

    acc_d       = acc_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Arithmetic shift then truncation to DATA_W is just the upper slice.
    avg = (acc_q + new_ext - old_ext) >> LOG2_DEPTH;

    if (accept) begin
      acc_d       = acc_q + new_ext - old_ext;
      wp_d        = wp_q + WpOne;
      cnt_d       = full ? cnt_q : cnt_q + CntOne;
      out_valid_d = 1'b1;
      out_data_d  = use_bypass ? in_data : acc_d[AccW-1:LOG2_DEPTH];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      sample_mem_q[wp_q] <= in_data;
    end
  end

  // avg is only a convenience view of the shifted sum; keep it referenced.
  logic avg_unused;
  assign avg_unused = ^avg;

endmodule

// File: tb/tb_audio_avg_filter.sv
module tb_audio_avg_filter;

  localparam int DW = 24;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          bypass;

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mon_exp;

  audio_avg_filter #(
    .DATA_W    (DW),
    .LOG2_DEPTH(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef AUDIO_AVG_BYPASS_EN
    ,
    .bypass   (bypass)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: an output is consumed on the next posedge when
  // out_valid && out_ready, so comparing at the negedge checks each once.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0d, required no output", $signed(out_data));
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL out_data: got %0d, required %0d", $signed(out_data), $signed(mon_exp));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add(input int d, input int e);
    vec_t v;
    v.data = DW'(d);
    v.exp  = DW'(e);
    vecs.push_back(v);
  endtask

  // Drive one sample; the expected result is pushed in the cycle it is taken.
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(vecs[i].data, vecs[i].exp);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_valid_in_reset"}, int'(out_valid), 0);
    check({tag, "_data_in_reset"}, $signed(out_data), 0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check({tag, "_valid_after"}, int'(out_valid), 0);
    check({tag, "_ready_after"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    bypass    = 1'b0;

    // 0..9: fill ramp
    for (int k = 1; k <= 10; k++) add(800, (k > 8 ? 8 : k) * 100);
    // 10..19: negative floor
    add(-9, -2); add(-9, -3); add(-9, -4); add(-9, -5);
    add(-9, -6); add(-9, -7); add(-9, -8); add(-9, -9);
    add(-9, -9); add(-9, -9);
    // 20..39: extremes, window wraps twice
    for (int k = 1; k <= 8; k++) add(8388607, k * 1048576 - 1);
    for (int j = 1; j <= 7; j++) add(-8388608, (8 - 2 * j) * 1048576 - 1);
    for (int j = 8; j <= 12; j++) add(-8388608, -8388608);
    // 40..44: partial fill before a mid-stream reset, 45: first after reset
    for (int k = 1; k <= 5; k++) add(800, k * 100);
    add(800, 100);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill ramp with full throughput
    stalls = 0;
    run_range(0, 9);
    check("ramp_no_stall", stalls, 0);
    drain();

    // Back-pressure: window is eight 800s; 400 gives 6000/8.
    send(DW'(400), DW'(750));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(1600);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", $signed(out_data), 750);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", int'(in_ready), 1);
    sb.push_back(DW'(850));  // 6*800 + 400 + 1600 = 6800
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_valid_kept", int'(out_valid), 1);
    drain();

    do_reset("neg");
    run_range(10, 19);
    drain();

    do_reset("ext");
    run_range(20, 39);
    drain();

    do_reset("mid0");
    run_range(40, 44);
    do_reset("mid");
    run_range(45, 45);
    drain();

`ifdef AUDIO_AVG_BYPASS_EN
    do_reset("byp");
    bypass = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(1000), DW'(1000));
    bypass = 1'b0;
    send(DW'(0), DW'(875));
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
